regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file with write-to-read bypass, a per-register busy scoreboard and a post-reset clear sequencer. It sits in the decode/writeback stage of the core. It serves NRD read ports and NWR writeback ports, and it tells issue logic which source registers still have an outstanding producer. Register 0 is hard-wired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, 8..64); AW = $clog2(NREGS)
- NRD, 2, read ports (1..4)
- NWR, 1, write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the stored value

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  read data (combinational)
- rd_busy  out  NRD  scoreboard bit of the addressed register
- wr_en  in  NWR  write enables
- wr_addr  in  NWR×AW  write addresses
- wr_data  in  NWR×XLEN  write data
- alloc_en  in  1  mark a destination register pending
- alloc_addr  in  AW  register to mark pending
- ready  out  1  high once the clear sequence has finished

## Operation
- FSM states: RF_CLEAR and RF_READY.
  - Reset assertion forces RF_CLEAR, sets clr_ptr=1 and clears all busy bits asynchronously.
  - Storage array has no reset; it is zeroed by the sequencer.
- In RF_CLEAR, each edge writes 0 to registry[clr_ptr] and increments clr_ptr. The edge that writes NREGS-1 moves the FSM to RF_READY.
- While in RF_CLEAR:
  - ready=0.
  - wr_en and alloc_en are ignored.
  - rd_data=0 and rd_busy=0.
- Register 0:
  - Reads return 0; writes and allocs to it are dropped.
  - rd_busy is always 0.
- Writes in RF_READY:
  - Port p with wr_en[p] and wr_addr[p]≠0 updates its register at the edge.
  - Both ports writing the same address: port NWR-1 wins.
- Bypass with BYPASS=1:
  - A read address matching an enabled, non-zero write this cycle returns that port's wr_data (highest matching port), and rd_busy=0.
  - With BYPASS=0, such a read returns the old value and the old busy bit.
- Scoreboard:
  - alloc_en sets busy[alloc_addr] at the edge.
  - Any enabled write clears busy[wr_addr] at the edge.
  - Alloc and write to the same register in one cycle: busy ends at 1, because the new producer wins.
- Widths: no arithmetic except clr_ptr (AW bits). clr_ptr never wraps, since the FSM leaves RF_CLEAR at NREGS-1.

## Timing
- Reset values:
  - ready=0, rd_busy=0, rd_data=0.
  - FSM in RF_CLEAR with clr_ptr=1.
- ready rises after exactly NREGS-1 rising edges following reset deassertion (31 for the defaults).
- Reads are combinational from rd_addr; a written value is visible from the cycle after the write edge, or in the same cycle via bypass.
- Busy bits are visible one cycle after alloc or write.
- Reset asserted mid-operation or mid-clear:
  - FSM returns to RF_CLEAR immediately and all busy bits clear.
  - The full clear restarts when reset deasserts.

## Structure
- Shared package regfile_pkg holds:
  - default XLEN and NREGS
  - typedef enum logic {RF_CLEAR, RF_READY} rf_state_t
  - typedefs for the reg_addr_t and xlen_t vectors
- Sub-module regfile_scoreboard holds the NREGS busy flops, the set/clear priority and the NRD busy read muxes.
- regfile_mp holds the storage array, the clear FSM, the write-port priority and the bypass muxes.

## Test plan
- Reset release, then poll ready:
  - ready=0 for 31 edges and 1 from edge 31.
  - Every register reads 0; writes issued during the clear are lost.
- Write port 0 x5=0xDEADBEEF, read x5 on both ports the next cycle → both return 0xDEADBEEF. Write x0=0x1234 → x0 reads 0.
- BYPASS=1: write x7=0xA5A5A5A5 while reading x7 in the same cycle → rd_data=0xA5A5A5A5 and rd_busy=0. BYPASS=0 → old value 0 returned.
- NWR=2, both ports write x9 (0x11 on port 0, 0x22 on port 1) → x9=0x22.
- Scoreboard sequence:
  - alloc x3 → next cycle rd_busy=1.
  - Write x3 → busy=0 the cycle after.
  - Alloc and write x3 in the same cycle → busy stays 1.
- Assert reset mid-run after filling x1..x31 with nonzero values, then release:
  - busy bits clear at once and ready drops.
  - After 31 edges all registers read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Clear sequencer states: zeroing the array after reset, then normal service.
  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  typedef logic [XLEN_DEF-1:0]          xlen_t;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_if.sv
// Register file access bundle: read ports, writeback ports, scoreboard alloc, ready.
// Latency: reads and busy lookups are combinational; writes and allocs land at the next edge.
// Backpressure: none; callers must hold off until ready is high.
// Ports: rd_addr/rd_data/rd_busy (NRD read ports), wr_en/wr_addr/wr_data (NWR writeback
//   ports), alloc_en/alloc_addr (mark destination pending), ready (clear finished).
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;
  logic                     ready;

  // Decode/issue side.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, ready
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: alloc sets, writeback clears, new producer wins a tie.
// Latency: set/clear visible one cycle after the edge; lookups are combinational.
// Backpressure: none; updates are ignored while en is low (clear sequence running).
// Ports: clk, reset (async active-low, clears all busy bits), en (file in service),
//   wr_en/wr_addr (writebacks), alloc_en/alloc_addr, rd_addr/rd_fwd (read ports and
//   their same-cycle forward hits), rd_busy (busy bit per read port).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  input  logic [NRD-1:0]         rd_fwd,
  output logic [NRD-1:0]         rd_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Clears are applied before the set so an alloc in the same cycle as a
  // writeback to that register leaves it pending for the new producer.
  always_comb begin
    busy_nxt = busy;
    if (en) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p] != '0) begin
          busy_nxt[wr_addr[p]] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != '0) begin
        busy_nxt[alloc_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // A forwarded read sees the value being produced, so it is never busy.
  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_busy[r] = en && (rd_addr[r] != '0) && !rd_fwd[r] && busy[rd_addr[r]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, busy scoreboard and post-reset clear.
// Latency: reads combinational; writes visible next cycle (same cycle when BYPASS=1); ready after NREGS-1 edges.
// Backpressure: none; writes and allocs presented while ready is low are dropped.
// Ports: clk, reset (async active-low), rf (regfile_if slave: rd_addr/rd_data/rd_busy,
//   wr_en/wr_addr/wr_data, alloc_en/alloc_addr, ready).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave rf
);

  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  rf_state_t                state;
  logic [AW-1:0]            clr_ptr;
  logic                     ready_q;
  logic                     run;
  logic [XLEN-1:0]          registry [NREGS];
  logic [NRD-1:0]           rd_fwd;
  logic [NRD-1:0][XLEN-1:0] rd_mux;
  logic [NRD-1:0]           busy_rd;

  assign run = (state == RF_READY);

  // Clear sequencer. x0 is never stored, so the sweep starts at 1 and stops on
  // the last register without incrementing, keeping clr_ptr from wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RF_CLEAR;
      clr_ptr <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          if (clr_ptr == LAST_REG) begin
            state   <= RF_READY;
            ready_q <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + AW'(1);
          end
        end
        RF_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state   <= RF_CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rf.ready = ready_q;

  // Storage has no reset; the sequencer zeroes it. Later ports are assigned
  // last, so the highest-numbered port wins an address collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      registry[clr_ptr] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (rf.wr_en[p] && rf.wr_addr[p] != '0) begin
          registry[rf.wr_addr[p]] <= rf.wr_data[p];
        end
      end
    end
  end

  // Read muxes: stored value, overridden by the highest matching writeback when
  // bypass is enabled, forced to zero for x0 and while clearing.
  always_comb begin
    rd_fwd = '0;
    rd_mux = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_mux[r] = registry[rf.rd_addr[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (rf.wr_en[p] && rf.wr_addr[p] != '0 && rf.wr_addr[p] == rf.rd_addr[r]) begin
            rd_fwd[r] = 1'b1;
            rd_mux[r] = rf.wr_data[p];
          end
        end
      end
      if (!run || rf.rd_addr[r] == '0) begin
        rd_mux[r] = '0;
      end
    end
  end

  assign rf.rd_data = rd_mux;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .en         (run),
    .wr_en      (rf.wr_en),
    .wr_addr    (rf.wr_addr),
    .alloc_en   (rf.alloc_en),
    .alloc_addr (rf.alloc_addr),
    .rd_addr    (rf.rd_addr),
    .rd_fwd     (rd_fwd),
    .rd_busy    (busy_rd)
  );

  assign rf.rd_busy = busy_rd;

endmodule
